// File: rtl/fp_pkg.sv
// Shared types, constants and helpers for the binary32 multiplier.
package fp_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned EXP_W  = 10;
  localparam int unsigned MANT_W = 24;
  localparam int unsigned PROD_W = 48;

  localparam int BIAS = 127;
  localparam int EMIN = -126;
  localparam int EMAX = 127;

  localparam logic [WORD_W-1:0] QNAN    = 32'h7FC0_0000;
  localparam logic [WORD_W-1:0] POS_INF = 32'h7F80_0000;

  typedef logic signed [EXP_W-1:0] exp_t;

  // GET is the all-zero encoding so a zero-initialised register starts in GET.
  typedef enum logic [2:0] {
    ST_GET        = 3'd0,
    ST_UNPACK     = 3'd1,
    ST_SPECIAL    = 3'd2,
    ST_MULTIPLY   = 3'd3,
    ST_NORMALISE  = 3'd4,
    ST_ROUND_PACK = 3'd5,
    ST_PUT_Z      = 3'd6
  } state_e;

  typedef struct packed {
    logic              sign;
    exp_t              exp;
    logic [MANT_W-1:0] mant;
  } fp_unpacked_t;

  typedef struct packed {
    logic              sign;
    exp_t              exp;
    logic [MANT_W-1:0] mant;
    logic              guard;
    logic              round;
    logic              sticky;
  } fp_work_t;

  function automatic fp_unpacked_t fp_unpack(input logic [WORD_W-1:0] w);
    fp_unpacked_t u;
    u.sign = w[31];
    if (w[30:23] == 8'd0) begin
      u.exp  = exp_t'(EMIN);
      u.mant = {1'b0, w[22:0]};
    end else begin
      u.exp  = exp_t'({2'b00, w[30:23]}) - exp_t'(BIAS);
      u.mant = {1'b1, w[22:0]};
    end
    return u;
  endfunction

  function automatic logic fp_is_nan(input fp_unpacked_t u);
    return ($signed(u.exp) == $signed(exp_t'(EMAX + 1))) && (u.mant[MANT_W-2:0] != '0);
  endfunction

  function automatic logic fp_is_inf(input fp_unpacked_t u);
    return ($signed(u.exp) == $signed(exp_t'(EMAX + 1))) && (u.mant[MANT_W-2:0] == '0);
  endfunction

  function automatic logic fp_is_zero(input fp_unpacked_t u);
    return ($signed(u.exp) == $signed(exp_t'(EMIN))) && (u.mant == '0);
  endfunction

  // One normalisation step: left shift toward a set MSB, or right shift up to EMIN.
  function automatic fp_work_t fp_norm_step(input fp_work_t w);
    fp_work_t n;
    n = w;
    if (!w.mant[MANT_W-1] && ($signed(w.exp) > $signed(exp_t'(EMIN)))) begin
      n.mant  = {w.mant[MANT_W-2:0], w.guard};
      n.guard = w.round;
      n.round = 1'b0;
      n.exp   = w.exp - exp_t'(1);
    end else if ($signed(w.exp) < $signed(exp_t'(EMIN))) begin
      n.mant   = {1'b0, w.mant[MANT_W-1:1]};
      n.guard  = w.mant[0];
      n.round  = w.guard;
      n.sticky = w.sticky | w.round;
      n.exp    = w.exp + exp_t'(1);
    end
    return n;
  endfunction

  function automatic logic fp_norm_done(input fp_work_t w);
    return !(!w.mant[MANT_W-1] && ($signed(w.exp) > $signed(exp_t'(EMIN))))
        && !($signed(w.exp) < $signed(exp_t'(EMIN)));
  endfunction

endpackage

// File: rtl/fp_multiplier_if.sv
// Operand/result stb-ack bundle of the multiplier; master drives operands.
interface fp_multiplier_if;
  import fp_pkg::*;

  logic [WORD_W-1:0] input_a;
  logic [WORD_W-1:0] input_b;
  logic              input_a_stb;
  logic              input_b_stb;
  logic              output_z_ack;
  logic [WORD_W-1:0] output_z;
  logic              output_z_stb;
  logic              input_a_ack;
  logic              input_b_ack;

  modport master (
    output input_a, input_b, input_a_stb, input_b_stb, output_z_ack,
    input  output_z, output_z_stb, input_a_ack, input_b_ack
  );

  modport slave (
    input  input_a, input_b, input_a_stb, input_b_stb, output_z_ack,
    output output_z, output_z_stb, input_a_ack, input_b_ack
  );
endinterface

// File: rtl/fp_round_pack.sv
// Combinational round-to-nearest-even and binary32 packing (overflow, denormals).
module fp_round_pack
  import fp_pkg::*;
(
  input  logic              sign_i,
  input  exp_t              exp_i,
  input  logic [MANT_W-1:0] mant_i,
  input  logic              guard_i,
  input  logic              round_i,
  input  logic              sticky_i,
  output logic [WORD_W-1:0] z_c_o
);

  logic              round_up_c;
  logic [MANT_W:0]   sum_c;
  logic [MANT_W-1:0] mant_r_c;
  exp_t              exp_r_c;
  logic [7:0]        exp_field_c;

  assign round_up_c  = guard_i & (round_i | sticky_i | mant_i[0]);
  assign sum_c       = {1'b0, mant_i} + (MANT_W + 1)'(round_up_c);
  // A carry out only happens from all-ones, so the shifted result is exact.
  assign mant_r_c    = sum_c[MANT_W] ? sum_c[MANT_W:1] : sum_c[MANT_W-1:0];
  assign exp_r_c     = sum_c[MANT_W] ? exp_i + exp_t'(1) : exp_i;
  assign exp_field_c = 8'(exp_r_c + exp_t'(BIAS));

  always_comb begin
    z_c_o = {sign_i, exp_field_c, mant_r_c[MANT_W-2:0]};
    if ($signed(exp_r_c) > $signed(exp_t'(EMAX))) begin
      z_c_o = {sign_i, POS_INF[30:0]};
    end else if (($signed(exp_r_c) == $signed(exp_t'(EMIN))) && !mant_r_c[MANT_W-1]) begin
      z_c_o = {sign_i, 8'h00, mant_r_c[MANT_W-2:0]};
    end
  end

endmodule

// File: rtl/fp_multiplier.sv
// Multi-cycle binary32 multiplier with independent stb/ack handshakes per operand and result.
module fp_multiplier
  import fp_pkg::*;
(
  input  logic [WORD_W-1:0] input_a,
  input  logic [WORD_W-1:0] input_b,
  input  logic              input_a_stb,
  input  logic              input_b_stb,
  input  logic              output_z_ack,
  input  logic              clk,
  input  logic              rst,
  output logic [WORD_W-1:0] output_z,
  output logic              output_z_stb,
  output logic              input_a_ack,
  output logic              input_b_ack
);

  state_e            state_q, state_d;
  logic [WORD_W-1:0] a_q, a_d, b_q, b_d;
  logic              a_held_q, a_held_d, b_held_q, b_held_d;
  logic              a_ack_q, a_ack_d, b_ack_q, b_ack_d;
  fp_unpacked_t      ua_q, ua_d, ub_q, ub_d;
  fp_work_t          work_q, work_d;
  logic [WORD_W-1:0] z_q, z_d;
  logic              z_stb_q, z_stb_d;

  logic              a_cap_c, b_cap_c, z_sign_c;
  logic [PROD_W-1:0] prod_c;
  logic [WORD_W-1:0] packed_c;

  assign a_cap_c  = input_a_stb & a_ack_q;
  assign b_cap_c  = input_b_stb & b_ack_q;
  assign z_sign_c = ua_q.sign ^ ub_q.sign;
  assign prod_c   = PROD_W'(ua_q.mant) * PROD_W'(ub_q.mant);

  fp_round_pack u_round_pack (
    .sign_i   (work_q.sign),
    .exp_i    (work_q.exp),
    .mant_i   (work_q.mant),
    .guard_i  (work_q.guard),
    .round_i  (work_q.round),
    .sticky_i (work_q.sticky),
    .z_c_o    (packed_c)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_GET;
      a_q      <= '0;
      b_q      <= '0;
      a_held_q <= 1'b0;
      b_held_q <= 1'b0;
      a_ack_q  <= 1'b1;
      b_ack_q  <= 1'b1;
      ua_q     <= '0;
      ub_q     <= '0;
      work_q   <= '0;
      z_q      <= '0;
      z_stb_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      a_held_q <= a_held_d;
      b_held_q <= b_held_d;
      a_ack_q  <= a_ack_d;
      b_ack_q  <= b_ack_d;
      ua_q     <= ua_d;
      ub_q     <= ub_d;
      work_q   <= work_d;
      z_q      <= z_d;
      z_stb_q  <= z_stb_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    a_held_d = a_held_q;
    b_held_d = b_held_q;
    ua_d     = ua_q;
    ub_d     = ub_q;
    work_d   = work_q;
    z_d      = z_q;
    z_stb_d  = z_stb_q;

    case (state_q)
      ST_GET: begin
        if (a_cap_c) a_d = input_a;
        if (b_cap_c) b_d = input_b;
        a_held_d = a_held_q | a_cap_c;
        b_held_d = b_held_q | b_cap_c;
        if (a_held_d && b_held_d) begin
          state_d  = ST_UNPACK;
          a_held_d = 1'b0;
          b_held_d = 1'b0;
        end
      end
      ST_UNPACK: begin
        ua_d    = fp_unpack(a_q);
        ub_d    = fp_unpack(b_q);
        state_d = ST_SPECIAL;
      end
      ST_SPECIAL: begin
        state_d = ST_PUT_Z;
        z_stb_d = 1'b1;
        if (fp_is_nan(ua_q) || fp_is_nan(ub_q) ||
            (fp_is_inf(ua_q) && fp_is_zero(ub_q)) ||
            (fp_is_zero(ua_q) && fp_is_inf(ub_q))) begin
          z_d = QNAN;
        end else if (fp_is_inf(ua_q) || fp_is_inf(ub_q)) begin
          z_d = {z_sign_c, POS_INF[30:0]};
        end else if (fp_is_zero(ua_q) || fp_is_zero(ub_q)) begin
          z_d = {z_sign_c, 31'd0};
        end else begin
          state_d = ST_MULTIPLY;
          z_stb_d = 1'b0;
        end
      end
      ST_MULTIPLY: begin
        work_d.sign   = z_sign_c;
        work_d.exp    = ua_q.exp + ub_q.exp + exp_t'(1);
        work_d.mant   = prod_c[PROD_W-1:PROD_W-MANT_W];
        work_d.guard  = prod_c[PROD_W-MANT_W-1];
        work_d.round  = prod_c[PROD_W-MANT_W-2];
        work_d.sticky = |prod_c[PROD_W-MANT_W-3:0];
        state_d       = ST_NORMALISE;
      end
      ST_NORMALISE: begin
        // Leave as soon as the post-step value needs no further shift.
        work_d = fp_norm_step(work_q);
        if (fp_norm_done(work_d)) state_d = ST_ROUND_PACK;
      end
      ST_ROUND_PACK: begin
        z_d     = packed_c;
        z_stb_d = 1'b1;
        state_d = ST_PUT_Z;
      end
      ST_PUT_Z: begin
        if (output_z_ack) begin
          z_stb_d = 1'b0;
          state_d = ST_GET;
        end
      end
      default: state_d = ST_GET;
    endcase

    a_ack_d = (state_d == ST_GET) && !a_held_d;
    b_ack_d = (state_d == ST_GET) && !b_held_d;
  end

  assign output_z     = z_q;
  assign output_z_stb = z_stb_q;
  assign input_a_ack  = a_ack_q;
  assign input_b_ack  = b_ack_q;

endmodule

// File: tb/tb_fp_multiplier.sv
// Directed and randomized self-checking bench for fp_multiplier against an exact-arithmetic model.
module tb_fp_multiplier;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  fp_multiplier_if bus ();

  fp_multiplier dut (
    .input_a      (bus.input_a),
    .input_b      (bus.input_b),
    .input_a_stb  (bus.input_a_stb),
    .input_b_stb  (bus.input_b_stb),
    .output_z_ack (bus.output_z_ack),
    .clk          (clk),
    .rst          (rst),
    .output_z     (bus.output_z),
    .output_z_stb (bus.output_z_stb),
    .input_a_ack  (bus.input_a_ack),
    .input_b_ack  (bus.input_b_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  // Exact product scaled to binary32 with round-to-nearest-even and gradual underflow.
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic sgn;
    longint unsigned ma, mb, p, kept, rem, half;
    int ea, eb, e0, msb, q, s, biased;
    sgn = a[31] ^ b[31];
    ma = 64'(a[22:0]);
    mb = 64'(b[22:0]);
    if (a[30:23] != 8'd0) ma = ma | 64'h80_0000;
    if (b[30:23] != 8'd0) mb = mb | 64'h80_0000;
    ea = (a[30:23] == 8'd0) ? -126 : int'(a[30:23]) - 127;
    eb = (b[30:23] == 8'd0) ? -126 : int'(b[30:23]) - 127;
    p = ma * mb;
    if (p == 64'd0) return {sgn, 31'd0};
    e0 = ea + eb - 46;
    msb = 63;
    while (p[msb] == 1'b0) msb--;
    q = msb + e0 - 23;
    if (q < -149) q = -149;
    s = q - e0;
    if (s > 62) begin
      kept = 64'd0;
    end else if (s > 0) begin
      kept = p >> s;
      rem  = p & ((64'd1 << s) - 64'd1);
      half = 64'd1 << (s - 1);
      if (rem > half || (rem == half && kept[0])) kept = kept + 64'd1;
    end else begin
      kept = p << (-s);
    end
    if (kept == (64'd1 << 24)) begin
      kept = kept >> 1;
      q++;
    end
    if (kept >= 64'h80_0000) begin
      biased = q + 23 + 127;
      if (biased >= 255) return {sgn, 8'hFF, 23'd0};
      return {sgn, biased[7:0], kept[22:0]};
    end
    return {sgn, 8'h00, kept[22:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ctl();
    return 32'({bus.output_z_stb, bus.input_a_ack, bus.input_b_ack});
  endfunction

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!(bus.input_a_ack && bus.input_b_ack) && n < 100) begin
      tick();
      n++;
    end
    check({tag, "_ready"}, 32'(bus.input_a_ack & bus.input_b_ack), 32'd1);
  endtask

  task automatic wait_result(input string tag, output logic [31:0] z, output int lat);
    lat = 0;
    while (!bus.output_z_stb && lat < 400) begin
      tick();
      lat++;
    end
    z = bus.output_z;
    check({tag, "_stb"}, 32'(bus.output_z_stb), 32'd1);
  endtask

  task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] z, output int lat);
    wait_ready(tag);
    bus.input_a     = a;
    bus.input_b     = b;
    bus.input_a_stb = 1'b1;
    bus.input_b_stb = 1'b1;
    tick();
    bus.input_a_stb = 1'b0;
    bus.input_b_stb = 1'b0;
    wait_result(tag, z, lat);
  endtask

  logic [31:0] va   [10] = '{32'h3FDEB852, 32'h40000000, 32'h7F800000, 32'h80000000, 32'h7F7FFFFF,
                             32'h00000001, 32'h7FC12345, 32'h7F800000, 32'h3FC00000, 32'h00000000};
  logic [31:0] vb   [10] = '{32'hC10C1893, 32'h40400000, 32'h00000000, 32'h3F800000, 32'h40000000,
                             32'h3F800000, 32'h3F800000, 32'hC0000000, 32'h3FC00000, 32'h7F800000};
  logic [31:0] vz   [10] = '{32'h00000000, 32'h40C00000, 32'h7FC00000, 32'h80000000, 32'h7F800000,
                             32'h00000001, 32'h7FC00000, 32'hFF800000, 32'h40100000, 32'h7FC00000};
  logic        vref [10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  int          vlat [10] = '{-1, 5, 2, 2, -1, -1, 2, 2, 5, 2};

  initial begin
    logic [31:0] z, exp_z, ra, rb;
    int lat, ea, eb;

    rst              = 1'b0;
    bus.input_a      = '0;
    bus.input_b      = '0;
    bus.input_a_stb  = 1'b0;
    bus.input_b_stb  = 1'b0;
    bus.output_z_ack = 1'b1;
    tick();
    check("reset_ctl", ctl(), 32'b011);
    check("reset_z", bus.output_z, 32'd0);
    rst = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) begin
      exp_z = vref[i] ? ref_mul(va[i], vb[i]) : vz[i];
      run_mul($sformatf("vec%0d", i), va[i], vb[i], z, lat);
      check($sformatf("vec%0d_z", i), z, exp_z);
      if (vlat[i] >= 0) check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vlat[i]));
      tick();
      check($sformatf("vec%0d_ret", i), ctl(), 32'b011);
    end

    // Result held while the consumer stalls; operand strobes must be ignored.
    bus.output_z_ack = 1'b0;
    run_mul("hold", 32'h40000000, 32'h40400000, z, lat);
    check("hold_z0", z, 32'h40C00000);
    bus.input_a     = 32'h3F800000;
    bus.input_b     = 32'h3F800000;
    bus.input_a_stb = 1'b1;
    bus.input_b_stb = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check($sformatf("hold_z_c%0d", i), bus.output_z, 32'h40C00000);
      check($sformatf("hold_ctl_c%0d", i), ctl(), 32'b100);
    end
    bus.input_a_stb  = 1'b0;
    bus.input_b_stb  = 1'b0;
    bus.output_z_ack = 1'b1;
    tick();
    check("hold_ret", ctl(), 32'b011);

    // B presented three cycles before A.
    wait_ready("bfirst");
    bus.input_b     = 32'h40400000;
    bus.input_b_stb = 1'b1;
    tick();
    bus.input_b_stb = 1'b0;
    bus.input_b     = 32'hDEADBEEF;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("bfirst_ctl_c%0d", i), ctl(), 32'b010);
      if (i < 2) tick();
    end
    bus.input_a     = 32'h3FC00000;
    bus.input_a_stb = 1'b1;
    tick();
    bus.input_a_stb = 1'b0;
    wait_result("bfirst", z, lat);
    check("bfirst_z", z, 32'h40900000);
    check("bfirst_lat", 32'(lat), 32'd5);

    // Reset while in NORMALISE discards the operation.
    wait_ready("rstmid");
    bus.input_a     = 32'h40000000;
    bus.input_b     = 32'h40400000;
    bus.input_a_stb = 1'b1;
    bus.input_b_stb = 1'b1;
    tick();
    bus.input_a_stb = 1'b0;
    bus.input_b_stb = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rstmid_ctl", ctl(), 32'b011);
    check("rstmid_z", bus.output_z, 32'd0);
    rst = 1'b1;
    repeat (6) tick();
    check("rstmid_nostale", ctl(), 32'b011);
    run_mul("after_rst", 32'h40000000, 32'h40400000, z, lat);
    check("after_rst_z", z, 32'h40C00000);

    // Random normal operands: wide exponents hit overflow/underflow, narrow ones stay normal.
    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0) begin
        ea = int'($urandom_range(1, 254));
        eb = int'($urandom_range(1, 254));
      end else begin
        ea = int'($urandom_range(100, 154));
        eb = int'($urandom_range(100, 154));
      end
      ra = {1'($urandom), 8'(ea), 23'($urandom)};
      rb = {1'($urandom), 8'(eb), 23'($urandom)};
      run_mul($sformatf("rnd%0d", i), ra, rb, z, lat);
      check($sformatf("rnd%0d_z(%h*%h)", i, ra, rb), z, ref_mul(ra, rb));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
